i2c_sram_slave_param: RTL

Parametrised successor to the embedded I2C SRAM slave. It oversamples SCL/SDA with a system clock instead of clocking on SCL. It generalises word width and memory depth, and adds multi-word auto-increment bursts, repeated-START handling and a write-commit strobe. It sits behind the board I2C pins as an addressable register/SRAM target.

---
 rtl/i2c_sram_slave_param_if.sv | 9 +
 rtl/i2c_sram_slave_param.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_sram_slave_param_if.sv
// Open-drain I2C pin bundle between the board pins and the SRAM slave.
interface i2c_sram_slave_param_if;
    logic scl_in;
    logic sda_in;
    logic sda_oe;

    modport slave  (input scl_in, input sda_in, output sda_oe);
    modport master (output scl_in, output sda_in, input sda_oe);
endinterface

// File: rtl/i2c_sram_slave_param.sv
// Oversampled I2C slave fronting a parametrised word SRAM: address bytes, then
// auto-incrementing word bursts for write or read, with repeated-START/STOP handling.
module i2c_sram_slave_param #(
    parameter int MEM_ADDR_W  = 8,
    parameter int WORD_BYTES  = 2,
    parameter int SYNC_STAGES = 2,
    parameter int AUTO_INC    = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    i2c_sram_slave_param_if.slave   i2c,
    input  logic [6:0]              my_addr,
    output logic [3:0]              state,
    output logic [6:0]              rcvd_device_address,
    output logic                    rcvd_mode,
    output logic [8*WORD_BYTES-1:0] curr_data,
    output logic [MEM_ADDR_W-1:0]   mem_addr,
    output logic                    wr_strobe,
    output logic                    busy
);
    localparam int WORD_W     = 8 * WORD_BYTES;
    localparam int ADDR_BYTES = (MEM_ADDR_W + 7) / 8;
    localparam int ACC_W      = 8 * ADDR_BYTES;
    localparam int DEPTH      = 1 << MEM_ADDR_W;
    localparam int NSYNC      = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int BIDX_W     = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int AIDX_W     = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;
    localparam logic [BIDX_W-1:0] LAST_BYTE  = BIDX_W'(WORD_BYTES - 1);
    localparam logic [AIDX_W-1:0] LAST_ABYTE = AIDX_W'(ADDR_BYTES - 1);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_DEV_ADDR  = 4'd1,
        S_DEV_ACK   = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_ACK   = 4'd4,
        S_WR_DATA   = 4'd5,
        S_WR_ACK    = 4'd6,
        S_RD_DATA   = 4'd7,
        S_RD_ACK    = 4'd8,
        S_WAIT_STOP = 4'd9
    } fsm_t;

    fsm_t                fsm_q, fsm_d;
    logic [NSYNC-1:0]    scl_sync, sda_sync;
    logic                scl_q, sda_q, scl_s, sda_s;
    logic                scl_rise, scl_fall, start_det, stop_det;
    logic [2:0]          bit_cnt, bit_cnt_d;
    logic [1:0]          ack_phase, ack_phase_d;
    logic [BIDX_W-1:0]   byte_idx, byte_idx_d;
    logic [AIDX_W-1:0]   addr_idx, addr_idx_d;
    logic [6:0]          shift, shift_d;
    logic [ACC_W-1:0]    addr_acc, addr_acc_d, acc_new;
    logic [WORD_W-1:0]   wr_word, wr_word_d, word_new;
    logic [WORD_W-1:0]   rd_word, rd_word_d, word_here, word_next;
    logic [7:0]          byte_in;
    logic [MEM_ADDR_W-1:0] addr_inc, mem_addr_d;
    logic                sda_oe_q, sda_oe_d, mem_we;
    logic [6:0]          rcvd_dev_d;
    logic                rcvd_mode_d, wr_strobe_d, busy_d;
    logic [WORD_W-1:0]   curr_data_d;
    logic [WORD_W-1:0]   mem [DEPTH];

    assign scl_s     = scl_sync[NSYNC-1];
    assign sda_s     = sda_sync[NSYNC-1];
    assign scl_rise  = scl_s & ~scl_q;
    assign scl_fall  = ~scl_s & scl_q;
    assign start_det = scl_s & scl_q & sda_q & ~sda_s;
    assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

    assign state      = fsm_q;
    assign i2c.sda_oe = sda_oe_q;
    assign addr_inc   = (AUTO_INC != 0) ? mem_addr + 1'b1 : mem_addr;
    assign word_here  = mem[mem_addr];
    assign word_next  = mem[addr_inc];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[NSYNC-2:0], i2c.scl_in};
            sda_sync <= {sda_sync[NSYNC-2:0], i2c.sda_in};
            scl_q    <= scl_s;
            sda_q    <= sda_s;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= word_new;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_q               <= S_IDLE;
            bit_cnt             <= '0;
            ack_phase           <= '0;
            byte_idx            <= '0;
            addr_idx            <= '0;
            shift               <= '0;
            addr_acc            <= '0;
            wr_word             <= '0;
            rd_word             <= '0;
            sda_oe_q            <= 1'b0;
            rcvd_device_address <= '0;
            rcvd_mode           <= 1'b0;
            curr_data           <= '0;
            mem_addr            <= '0;
            wr_strobe           <= 1'b0;
            busy                <= 1'b0;
        end else begin
            fsm_q               <= fsm_d;
            bit_cnt             <= bit_cnt_d;
            ack_phase           <= ack_phase_d;
            byte_idx            <= byte_idx_d;
            addr_idx            <= addr_idx_d;
            shift               <= shift_d;
            addr_acc            <= addr_acc_d;
            wr_word             <= wr_word_d;
            rd_word             <= rd_word_d;
            sda_oe_q            <= sda_oe_d;
            rcvd_device_address <= rcvd_dev_d;
            rcvd_mode           <= rcvd_mode_d;
            curr_data           <= curr_data_d;
            mem_addr            <= mem_addr_d;
            wr_strobe           <= wr_strobe_d;
            busy                <= busy_d;
        end
    end

    always_comb begin
        fsm_d       = fsm_q;
        bit_cnt_d   = bit_cnt;
        ack_phase_d = ack_phase;
        byte_idx_d  = byte_idx;
        addr_idx_d  = addr_idx;
        shift_d     = shift;
        addr_acc_d  = addr_acc;
        wr_word_d   = wr_word;
        rd_word_d   = rd_word;
        sda_oe_d    = sda_oe_q;
        rcvd_dev_d  = rcvd_device_address;
        rcvd_mode_d = rcvd_mode;
        curr_data_d = curr_data;
        mem_addr_d  = mem_addr;
        wr_strobe_d = 1'b0;
        busy_d      = busy;
        mem_we      = 1'b0;
        byte_in     = {shift, sda_s};
        acc_new     = (addr_acc << 8) | ACC_W'(byte_in);
        word_new    = (wr_word << 8) | WORD_W'(byte_in);

        if (stop_det) begin
            fsm_d    = S_IDLE;
            busy_d   = 1'b0;
            sda_oe_d = 1'b0;
        end else if (start_det) begin
            fsm_d       = S_DEV_ADDR;
            busy_d      = 1'b1;
            sda_oe_d    = 1'b0;
            bit_cnt_d   = '0;
            ack_phase_d = '0;
            byte_idx_d  = '0;
            addr_idx_d  = '0;
        end else begin
            case (fsm_q)
                S_DEV_ADDR, S_MEM_ADDR, S_WR_DATA: begin
                    if (scl_rise) begin
                        shift_d   = byte_in[6:0];
                        bit_cnt_d = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            ack_phase_d = '0;
                            if (fsm_q == S_DEV_ADDR) begin
                                rcvd_dev_d  = byte_in[7:1];
                                rcvd_mode_d = byte_in[0];
                                fsm_d = (byte_in[7:1] == my_addr) ? S_DEV_ACK : S_WAIT_STOP;
                            end else if (fsm_q == S_MEM_ADDR) begin
                                // Older address bytes shift out the top, so unused high bits drop away.
                                addr_acc_d = acc_new;
                                if (addr_idx == LAST_ABYTE) mem_addr_d = acc_new[MEM_ADDR_W-1:0];
                                fsm_d = S_MEM_ACK;
                            end else begin
                                wr_word_d = word_new;
                                if (byte_idx == LAST_BYTE) begin
                                    mem_we      = 1'b1;
                                    curr_data_d = word_new;
                                    wr_strobe_d = 1'b1;
                                    mem_addr_d  = addr_inc;
                                    byte_idx_d  = '0;
                                end else begin
                                    byte_idx_d = byte_idx + 1'b1;
                                end
                                fsm_d = S_WR_ACK;
                            end
                        end
                    end
                end
                S_DEV_ACK, S_MEM_ACK, S_WR_ACK: begin
                    if (scl_fall) begin
                        if (ack_phase == 2'd0) begin
                            sda_oe_d    = 1'b1;
                            ack_phase_d = 2'd1;
                        end else begin
                            sda_oe_d    = 1'b0;
                            ack_phase_d = 2'd0;
                            bit_cnt_d   = '0;
                            if (fsm_q == S_DEV_ACK) begin
                                addr_idx_d = '0;
                                fsm_d      = S_MEM_ADDR;
                            end else if (fsm_q == S_WR_ACK) begin
                                fsm_d = S_WR_DATA;
                            end else if (addr_idx != LAST_ABYTE) begin
                                addr_idx_d = addr_idx + 1'b1;
                                fsm_d      = S_MEM_ADDR;
                            end else if (rcvd_mode) begin
                                byte_idx_d  = '0;
                                rd_word_d   = word_here;
                                curr_data_d = word_here;
                                sda_oe_d    = ~word_here[WORD_W-1];
                                fsm_d       = S_RD_DATA;
                            end else begin
                                byte_idx_d = '0;
                                fsm_d      = S_WR_DATA;
                            end
                        end
                    end
                end
                S_RD_DATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            ack_phase_d = 2'd0;
                            fsm_d       = S_RD_ACK;
                        end
                    end else if (scl_fall) begin
                        rd_word_d = rd_word << 1;
                        sda_oe_d  = ~rd_word[WORD_W-2];
                    end
                end
                S_RD_ACK: begin
                    // Phase 0: release for master ACK; 1: sample it; 2: drive next byte's MSB.
                    if (scl_fall) begin
                        if (ack_phase == 2'd0) begin
                            sda_oe_d    = 1'b0;
                            ack_phase_d = 2'd1;
                        end else if (ack_phase == 2'd2) begin
                            ack_phase_d = 2'd0;
                            bit_cnt_d   = '0;
                            fsm_d       = S_RD_DATA;
                            if (byte_idx != LAST_BYTE) begin
                                byte_idx_d = byte_idx + 1'b1;
                                rd_word_d  = rd_word << 1;
                                sda_oe_d   = ~rd_word[WORD_W-2];
                            end else begin
                                byte_idx_d  = '0;
                                mem_addr_d  = addr_inc;
                                rd_word_d   = word_next;
                                curr_data_d = word_next;
                                sda_oe_d    = ~word_next[WORD_W-1];
                            end
                        end
                    end else if (scl_rise && ack_phase == 2'd1) begin
                        if (sda_s) fsm_d = S_WAIT_STOP;
                        else ack_phase_d = 2'd2;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
